inst_buffer: RTL and testbench

- Decoupling instruction queue between the branch-prediction/fetch stage and decode.
- Accepts up to two fetched instructions per cycle, each with PC, branch tag, predicted-taken tag and exception info, in the fetch stage's slot-1/slot-2 order.
- Presents up to two oldest entries per cycle to dual-issue decode.
- Absorbs decode stalls and is emptied on branch flush.

---
 rtl/inst_buffer.sv | 196 +++++++++++++++++++
 tb/tb_inst_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// inst_buffer: dual-enqueue / dual-dequeue instruction queue between fetch and decode.
// Circular register array with separate head, tail and occupancy count.
// Optional macro IBUF_BYPASS_EN: when the queue is empty, fetched slots are presented
// to decode in the same cycle and only the slots decode does not take are stored.
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int EXC_W = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid_1,
    input  logic                       enq_valid_2,
    input  logic [31:0]                enq_inst_1,
    input  logic [31:0]                enq_inst_2,
    input  logic [31:0]                enq_pc_1,
    input  logic [31:0]                enq_pc_2,
    input  logic                       enq_is_branch_1,
    input  logic                       enq_is_branch_2,
    input  logic                       enq_pre_taken_1,
    input  logic                       enq_pre_taken_2,
    input  logic                       enq_is_exc,
    input  logic [EXC_W-1:0]           enq_exc_cause,
    output logic                       enq_ready,
    output logic                       deq_valid_1,
    output logic                       deq_valid_2,
    input  logic                       deq_ready_1,
    input  logic                       deq_ready_2,
    output logic [31:0]                deq_inst_1,
    output logic [31:0]                deq_inst_2,
    output logic [31:0]                deq_pc_1,
    output logic [31:0]                deq_pc_2,
    output logic                       deq_is_branch_1,
    output logic                       deq_is_branch_2,
    output logic                       deq_pre_taken_1,
    output logic                       deq_pre_taken_2,
    output logic                       deq_is_exc_1,
    output logic                       deq_is_exc_2,
    output logic [EXC_W-1:0]           deq_exc_cause_1,
    output logic [EXC_W-1:0]           deq_exc_cause_2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_TWO = CW'(2);

    // storage (no reset needed; validity is tracked by count)
    logic [31:0]      inst_q  [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic             br_q    [DEPTH];
    logic             pt_q    [DEPTH];
    logic             exc_q   [DEPTH];
    logic [EXC_W-1:0] cause_q [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_p1, tail_p1;

    logic acc1, acc2, take1, take2, we1, we2, v1, v2;
    logic [1:0] n_enq, n_deq;
`ifdef IBUF_BYPASS_EN
    logic bypass;
`endif

    assign head_p1 = head_q + PW'(1);
    assign tail_p1 = tail_q + PW'(1);
    assign count   = count_q;
    assign deq_valid_1 = v1;
    assign deq_valid_2 = v2;

    // handshake, occupancy and next-pointer computation
    always_comb begin
        enq_ready = (count_q <= RDY_MAX);
        // slot 2 is only meaningful together with slot 1
        acc1  = enq_ready & ~flush & enq_valid_1;
        acc2  = acc1 & enq_valid_2;
        n_enq = {1'b0, acc1} + {1'b0, acc2};
        v1    = (count_q != '0);
        v2    = (count_q >= CNT_TWO);
`ifdef IBUF_BYPASS_EN
        bypass = (count_q == '0) & ~flush;
        if (bypass) begin
            v1 = acc1;
            v2 = acc2;
        end
`endif
        // decode consumes strictly in order: slot 2 only together with slot 1
        take1 = v1 & deq_ready_1;
        take2 = v2 & deq_ready_2 & take1;
        n_deq = {1'b0, take1} + {1'b0, take2};
        we1   = acc1;
        we2   = acc2;
`ifdef IBUF_BYPASS_EN
        // bypassed slots already consumed are skipped; the rest land at head onwards
        if (bypass) begin
            we1 = acc1 & ~take1;
            we2 = acc2 & ~take2;
        end
`endif
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(n_deq);
            tail_d  = tail_q + PW'(n_enq);
            count_d = count_q + CW'(n_enq) - CW'(n_deq);
        end
    end

    // dequeue data: head / head+1 (or live fetch slots when bypassing), zero when invalid
    always_comb begin
        deq_inst_1      = '0;
        deq_pc_1        = '0;
        deq_is_branch_1 = 1'b0;
        deq_pre_taken_1 = 1'b0;
        deq_is_exc_1    = 1'b0;
        deq_exc_cause_1 = '0;
        deq_inst_2      = '0;
        deq_pc_2        = '0;
        deq_is_branch_2 = 1'b0;
        deq_pre_taken_2 = 1'b0;
        deq_is_exc_2    = 1'b0;
        deq_exc_cause_2 = '0;
        if (v1) begin
            deq_inst_1      = inst_q[head_q];
            deq_pc_1        = pc_q[head_q];
            deq_is_branch_1 = br_q[head_q];
            deq_pre_taken_1 = pt_q[head_q];
            deq_is_exc_1    = exc_q[head_q];
            deq_exc_cause_1 = cause_q[head_q];
        end
        if (v2) begin
            deq_inst_2      = inst_q[head_p1];
            deq_pc_2        = pc_q[head_p1];
            deq_is_branch_2 = br_q[head_p1];
            deq_pre_taken_2 = pt_q[head_p1];
            deq_is_exc_2    = exc_q[head_p1];
            deq_exc_cause_2 = cause_q[head_p1];
        end
`ifdef IBUF_BYPASS_EN
        if (bypass && v1) begin
            deq_inst_1      = enq_inst_1;
            deq_pc_1        = enq_pc_1;
            deq_is_branch_1 = enq_is_branch_1;
            deq_pre_taken_1 = enq_pre_taken_1;
            deq_is_exc_1    = enq_is_exc;
            deq_exc_cause_1 = enq_exc_cause;
        end
        if (bypass && v2) begin
            deq_inst_2      = enq_inst_2;
            deq_pc_2        = enq_pc_2;
            deq_is_branch_2 = enq_is_branch_2;
            deq_pre_taken_2 = enq_pre_taken_2;
            deq_is_exc_2    = enq_is_exc;
            deq_exc_cause_2 = enq_exc_cause;
        end
`endif
    end

    // pointer and count registers; reset beats flush
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // entry writes: slot 1 at tail, slot 2 at tail+1 (may wrap to index 0)
    always_ff @(posedge clk) begin
        if (we1) begin
            inst_q[tail_q]  <= enq_inst_1;
            pc_q[tail_q]    <= enq_pc_1;
            br_q[tail_q]    <= enq_is_branch_1;
            pt_q[tail_q]    <= enq_pre_taken_1;
            exc_q[tail_q]   <= enq_is_exc;
            cause_q[tail_q] <= enq_exc_cause;
        end
        if (we2) begin
            inst_q[tail_p1]  <= enq_inst_2;
            pc_q[tail_p1]    <= enq_pc_2;
            br_q[tail_p1]    <= enq_is_branch_2;
            pt_q[tail_p1]    <= enq_pre_taken_2;
            exc_q[tail_p1]   <= enq_is_exc;
            cause_q[tail_p1] <= enq_exc_cause;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed stimulus against a queue-based reference model of inst_buffer.
module tb_inst_buffer;
    localparam int DEPTH = 8;
    localparam int EXC_W = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, enq_valid_1, enq_valid_2;
    logic [31:0] enq_inst_1, enq_inst_2, enq_pc_1, enq_pc_2;
    logic enq_is_branch_1, enq_is_branch_2, enq_pre_taken_1, enq_pre_taken_2;
    logic enq_is_exc;
    logic [EXC_W-1:0] enq_exc_cause;
    logic enq_ready, deq_valid_1, deq_valid_2, deq_ready_1, deq_ready_2;
    logic [31:0] deq_inst_1, deq_inst_2, deq_pc_1, deq_pc_2;
    logic deq_is_branch_1, deq_is_branch_2, deq_pre_taken_1, deq_pre_taken_2;
    logic deq_is_exc_1, deq_is_exc_2;
    logic [EXC_W-1:0] deq_exc_cause_1, deq_exc_cause_2;
    logic [$clog2(DEPTH):0] count;

    inst_buffer #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid_1(enq_valid_1), .enq_valid_2(enq_valid_2),
        .enq_inst_1(enq_inst_1), .enq_inst_2(enq_inst_2),
        .enq_pc_1(enq_pc_1), .enq_pc_2(enq_pc_2),
        .enq_is_branch_1(enq_is_branch_1), .enq_is_branch_2(enq_is_branch_2),
        .enq_pre_taken_1(enq_pre_taken_1), .enq_pre_taken_2(enq_pre_taken_2),
        .enq_is_exc(enq_is_exc), .enq_exc_cause(enq_exc_cause),
        .enq_ready(enq_ready),
        .deq_valid_1(deq_valid_1), .deq_valid_2(deq_valid_2),
        .deq_ready_1(deq_ready_1), .deq_ready_2(deq_ready_2),
        .deq_inst_1(deq_inst_1), .deq_inst_2(deq_inst_2),
        .deq_pc_1(deq_pc_1), .deq_pc_2(deq_pc_2),
        .deq_is_branch_1(deq_is_branch_1), .deq_is_branch_2(deq_is_branch_2),
        .deq_pre_taken_1(deq_pre_taken_1), .deq_pre_taken_2(deq_pre_taken_2),
        .deq_is_exc_1(deq_is_exc_1), .deq_is_exc_2(deq_is_exc_2),
        .deq_exc_cause_1(deq_exc_cause_1), .deq_exc_cause_2(deq_exc_cause_2),
        .count(count)
    );

    typedef struct packed {
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic             br;
        logic             pt;
        logic             exc;
        logic [EXC_W-1:0] cause;
    } ent_t;

    ent_t q[$];
    ent_t enql[$];
    ent_t exp_e1, exp_e2;
    logic exp_v1, exp_v2, exp_rdy;
    int   exp_cnt, exp_n;
    logic [31:0] pc_next;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // expected outputs for the current state and currently driven inputs
    function automatic void compute_exp();
        ent_t view[$];
        ent_t e;
        enql.delete();
        if (q.size() <= DEPTH - 2 && !flush && enq_valid_1) begin
            e = '{enq_inst_1, enq_pc_1, enq_is_branch_1, enq_pre_taken_1, enq_is_exc, enq_exc_cause};
            enql.push_back(e);
            if (enq_valid_2) begin
                e = '{enq_inst_2, enq_pc_2, enq_is_branch_2, enq_pre_taken_2, enq_is_exc, enq_exc_cause};
                enql.push_back(e);
            end
        end
        view = q;
`ifdef IBUF_BYPASS_EN
        if (q.size() == 0 && !flush) view = enql;
`endif
        exp_v1  = (view.size() >= 1);
        exp_v2  = (view.size() >= 2);
        exp_e1  = exp_v1 ? view[0] : '0;
        exp_e2  = exp_v2 ? view[1] : '0;
        exp_n   = int'(exp_v1 && deq_ready_1) + int'(exp_v2 && deq_ready_2 && deq_ready_1);
        exp_rdy = (q.size() <= DEPTH - 2);
        exp_cnt = q.size();
    endfunction

    // model state after a clock edge: append accepted slots, then retire the oldest n
    function automatic void update_model();
        if (rst || flush) begin
            q.delete();
        end else begin
            foreach (enql[i]) q.push_back(enql[i]);
            pc_next = pc_next + 32'(4 * enql.size());
            for (int k = 0; k < exp_n; k++) void'(q.pop_front());
        end
    endfunction

    task automatic set_in(input bit v1, input bit v2, input bit r1, input bit r2,
                          input bit fl, input bit ex, input logic [EXC_W-1:0] cs, input bit rs);
        rst = rs; flush = fl;
        enq_valid_1 = v1; enq_valid_2 = v2;
        enq_pc_1 = pc_next; enq_pc_2 = pc_next + 32'd4;
        enq_inst_1 = enq_pc_1 ^ 32'hA5A5_0000; enq_inst_2 = enq_pc_2 ^ 32'hA5A5_0000;
        enq_is_branch_1 = enq_pc_1[3]; enq_is_branch_2 = enq_pc_2[3];
        enq_pre_taken_1 = enq_pc_1[4]; enq_pre_taken_2 = enq_pc_2[4];
        enq_is_exc = ex; enq_exc_cause = cs;
        deq_ready_1 = r1; deq_ready_2 = r2;
        compute_exp();
    endtask

    task automatic cyc(input bit v1, input bit v2, input bit r1, input bit r2,
                       input bit fl, input bit ex, input logic [EXC_W-1:0] cs, input bit rs);
        set_in(v1, v2, r1, r2, fl, ex, cs, rs);
        @(posedge clk);
        update_model();
        #1;
        set_in(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("enq_ready", 128'(enq_ready), 128'(exp_rdy));
            chk("count", 128'(count), 128'(exp_cnt));
            chk("deq_valid_1", 128'(deq_valid_1), 128'(exp_v1));
            chk("deq_valid_2", 128'(deq_valid_2), 128'(exp_v2));
            chk("deq_ent_1", 128'({deq_inst_1, deq_pc_1, deq_is_branch_1, deq_pre_taken_1,
                                   deq_is_exc_1, deq_exc_cause_1}), 128'(exp_e1));
            chk("deq_ent_2", 128'({deq_inst_2, deq_pc_2, deq_is_branch_2, deq_pre_taken_2,
                                   deq_is_exc_2, deq_exc_cause_2}), 128'(exp_e2));
        end
    end

    logic [31:0] pc_save;

    initial begin
        pc_next = 32'h1c00_0000;
        set_in(0, 0, 0, 0, 0, 0, '0, 1);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, '0, 1);
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_valid", 128'({deq_valid_1, deq_valid_2}), 128'(0));
        chk("rst_ready", 128'(enq_ready), 128'(1));

        // first pair, decode stalled
        cyc(1, 1, 0, 0, 0, 0, '0, 0);
        chk("pair_count", 128'(count), 128'(2));
        chk("pair_valid", 128'({deq_valid_1, deq_valid_2}), 128'(2'b11));
        chk("pair_pc1", 128'(deq_pc_1), 128'(32'h1c00_0000));
        chk("pair_pc2", 128'(deq_pc_2), 128'(32'h1c00_0004));

        // fill to full, then enqueues are dropped
        repeat (3) cyc(1, 1, 0, 0, 0, 0, '0, 0);
        chk("full_count", 128'(count), 128'(8));
        chk("full_ready", 128'(enq_ready), 128'(0));
        repeat (2) cyc(1, 1, 0, 0, 0, 0, '0, 0);
        chk("full_hold", 128'(count), 128'(8));
        cyc(0, 0, 0, 1, 0, 0, '0, 0);
        chk("rdy2_only", 128'(count), 128'(8));

        // drain one per cycle in order
        repeat (8) cyc(0, 0, 1, 0, 0, 0, '0, 0);
        chk("drain_count", 128'(count), 128'(0));
        chk("drain_valid", 128'(deq_valid_1), 128'(0));

        // slot 2 alone is illegal and ignored
        cyc(0, 1, 0, 0, 0, 0, '0, 0);
        chk("v2_only", 128'(count), 128'(0));

        // count 7: enq_ready low, same-cycle dequeue not credited
        repeat (3) cyc(1, 1, 0, 0, 0, 0, '0, 0);
        cyc(1, 0, 0, 0, 0, 0, '0, 0);
        chk("seven_count", 128'(count), 128'(7));
        chk("seven_ready", 128'(enq_ready), 128'(0));
        cyc(1, 1, 1, 0, 0, 0, '0, 0);
        chk("seven_drop", 128'(count), 128'(6));
        repeat (3) cyc(0, 0, 1, 1, 0, 0, '0, 0);
        chk("empty_again", 128'(count), 128'(0));

        // steady state from count 3
        cyc(1, 1, 0, 0, 0, 0, '0, 0);
        cyc(1, 0, 0, 0, 0, 0, '0, 0);
        repeat (20) cyc(1, 1, 1, 1, 0, 0, '0, 0);
        chk("steady_count", 128'(count), 128'(3));
        chk("steady_pc", 128'(deq_pc_1), 128'(pc_next - 32'd12));

        // exception pair
        cyc(0, 0, 1, 1, 0, 0, '0, 0);
        cyc(0, 0, 1, 0, 0, 0, '0, 0);
        cyc(1, 1, 0, 0, 0, 1, 7'h08, 0);
        chk("exc_flags", 128'({deq_is_exc_1, deq_is_exc_2}), 128'(2'b11));
        chk("exc_cause1", 128'(deq_exc_cause_1), 128'(7'h08));
        chk("exc_cause2", 128'(deq_exc_cause_2), 128'(7'h08));

        // flush at count 5 with simultaneous enqueue and dequeue
        cyc(1, 1, 0, 0, 0, 0, '0, 0);
        cyc(1, 0, 0, 0, 0, 0, '0, 0);
        chk("pre_flush", 128'(count), 128'(5));
        cyc(1, 1, 1, 1, 1, 0, '0, 0);
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_valid", 128'(deq_valid_1), 128'(0));
        chk("flush_ready", 128'(enq_ready), 128'(1));
        pc_save = pc_next;
        cyc(1, 1, 0, 0, 0, 0, '0, 0);
        chk("post_flush_pc", 128'(deq_pc_1), 128'(pc_save));

        // reset mid-operation, with an enqueue pending
        cyc(1, 1, 1, 0, 0, 0, '0, 1);
        chk("midrst_count", 128'(count), 128'(0));

        // mixed pattern sweep
        for (int i = 0; i < 60; i++)
            cyc(i % 4 != 3, i % 3 != 0, i % 5 != 2, i % 2 == 1, i == 37, i % 7 == 0, 7'(i), 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
